// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } arb_state_e;

    localparam int DEF_TAG_W   = 4;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_MAX_OUT = 8;
    localparam int ADDR_W      = 26;

    // Downstream tags carry the requester ID just above the upstream tag bits.
    function automatic int rid_bit(input int tag_w);
        return tag_w;
    endfunction

endpackage

// File: rtl/mem_arb_out_tracker.sv
// Per-requester outstanding-read counter; a read line retires on its last response beat.
module mem_arb_out_tracker
    import mem_arb_pkg::*;
#(
    parameter int BEATS   = DEF_BEATS,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic host_clk,
    input  logic reset,
    input  logic rd_issue_i,
    input  logic resp_beat_i,
    output logic can_read_o
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(MAX_OUT) + 1;

    logic [BW-1:0] rbeat_q, rbeat_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          line_done;
    logic          inc, dec;

    always_comb begin
        rbeat_d   = rbeat_q;
        line_done = 1'b0;
        if (resp_beat_i) begin
            if (rbeat_q == BW'(BEATS - 1)) begin
                rbeat_d   = '0;
                line_done = 1'b1;
            end else begin
                rbeat_d = rbeat_q + 1'b1;
            end
        end
    end

    // A stray line with nothing outstanding must not wrap the counter.
    assign inc = rd_issue_i;
    assign dec = line_done && ((out_cnt_q != '0) || inc);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (inc && !dec) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!inc && dec) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge host_clk) begin
        if (reset) begin
            rbeat_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            rbeat_q   <= rbeat_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign can_read_o = (out_cnt_q < CW'(MAX_OUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MemIO port between the core (r0) and a host loader (r1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BEATS   = DEF_BEATS,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic              host_clk,
    input  logic              reset,

    input  logic              r0_cmd_valid,
    output logic              r0_cmd_ready,
    input  logic [25:0]       r0_cmd_addr,
    input  logic [TAG_W-1:0]  r0_cmd_tag,
    input  logic              r0_cmd_rw,
    input  logic              r0_data_valid,
    output logic              r0_data_ready,
    input  logic [DATA_W-1:0] r0_data_bits,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [DATA_W-1:0] r0_resp_data,
    output logic [TAG_W-1:0]  r0_resp_tag,

    input  logic              r1_cmd_valid,
    output logic              r1_cmd_ready,
    input  logic [25:0]       r1_cmd_addr,
    input  logic [TAG_W-1:0]  r1_cmd_tag,
    input  logic              r1_cmd_rw,
    input  logic              r1_data_valid,
    output logic              r1_data_ready,
    input  logic [DATA_W-1:0] r1_data_bits,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [DATA_W-1:0] r1_resp_data,
    output logic [TAG_W-1:0]  r1_resp_tag,

    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [25:0]       m_cmd_addr,
    output logic [TAG_W:0]    m_cmd_tag,
    output logic              m_cmd_rw,
    output logic              m_data_valid,
    input  logic              m_data_ready,
    output logic [DATA_W-1:0] m_data_bits,
    input  logic              m_resp_valid,
    output logic              m_resp_ready,
    input  logic [DATA_W-1:0] m_resp_data,
    input  logic [TAG_W:0]    m_resp_tag
);

    localparam int RID = rid_bit(TAG_W);
    localparam int WB  = (BEATS > 1) ? $clog2(BEATS) : 1;

    arb_state_e          state_q;
    logic                gnt_q;
    logic                prio_q;
    logic [WB-1:0]       wbeat_q;
    logic                wdone_q;
    logic                cmd_valid_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [TAG_W:0]      cmd_tag_q;
    logic                cmd_rw_q;

    logic can_read0, can_read1;
    logic elig0, elig1, pick1;
    logic cmd_hs, data_phase, data_hs, last_beat;
    logic resp_sel;

    assign elig0 = r0_cmd_valid && (r0_cmd_rw || can_read0);
    assign elig1 = r1_cmd_valid && (r1_cmd_rw || can_read1);
    assign pick1 = elig1 && (!elig0 || prio_q);

    assign cmd_hs = cmd_valid_q && m_cmd_ready;

    // The bridge wants write data alongside the command, so the data mux opens in CMD too.
    assign data_phase = ((state_q == CMD) || (state_q == WDATA)) && cmd_rw_q && !wdone_q;
    assign data_hs    = m_data_valid && m_data_ready;
    assign last_beat  = data_hs && (wbeat_q == WB'(BEATS - 1));

    assign m_cmd_valid = cmd_valid_q;
    assign m_cmd_addr  = cmd_addr_q;
    assign m_cmd_tag   = cmd_tag_q;
    assign m_cmd_rw    = cmd_rw_q;

    assign r0_cmd_ready = cmd_valid_q && !gnt_q && m_cmd_ready;
    assign r1_cmd_ready = cmd_valid_q &&  gnt_q && m_cmd_ready;

    assign m_data_valid  = data_phase && (gnt_q ? r1_data_valid : r0_data_valid);
    assign m_data_bits   = data_phase ? (gnt_q ? r1_data_bits : r0_data_bits) : '0;
    assign r0_data_ready = data_phase && !gnt_q && m_data_ready;
    assign r1_data_ready = data_phase &&  gnt_q && m_data_ready;

    assign resp_sel      = m_resp_tag[RID];
    assign r0_resp_valid = m_resp_valid && !resp_sel;
    assign r1_resp_valid = m_resp_valid &&  resp_sel;
    assign r0_resp_data  = m_resp_data;
    assign r1_resp_data  = m_resp_data;
    assign r0_resp_tag   = m_resp_tag[TAG_W-1:0];
    assign r1_resp_tag   = m_resp_tag[TAG_W-1:0];
    assign m_resp_ready  = resp_sel ? r1_resp_ready : r0_resp_ready;

    always_ff @(posedge host_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            prio_q      <= 1'b0;
            wbeat_q     <= '0;
            wdone_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_tag_q   <= '0;
            cmd_rw_q    <= 1'b0;
        end else begin
            if (data_hs) begin
                wbeat_q <= last_beat ? '0 : wbeat_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (elig0 || elig1) begin
                        gnt_q       <= pick1;
                        cmd_valid_q <= 1'b1;
                        cmd_addr_q  <= pick1 ? r1_cmd_addr : r0_cmd_addr;
                        cmd_tag_q   <= {pick1, (pick1 ? r1_cmd_tag : r0_cmd_tag)};
                        cmd_rw_q    <= pick1 ? r1_cmd_rw : r0_cmd_rw;
                        wdone_q     <= 1'b0;
                        state_q     <= CMD;
                    end
                end
                CMD: begin
                    if (last_beat) begin
                        wdone_q <= 1'b1;
                    end
                    if (cmd_hs) begin
                        cmd_valid_q <= 1'b0;
                        prio_q      <= ~prio_q;
                        // A write whose whole line already went out with the command is finished.
                        if (!cmd_rw_q || wdone_q || last_beat) begin
                            wdone_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (last_beat) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_arb_out_tracker #(
        .BEATS   (BEATS),
        .MAX_OUT (MAX_OUT)
    ) u_trk0 (
        .host_clk    (host_clk),
        .reset       (reset),
        .rd_issue_i  (cmd_hs && !gnt_q && !cmd_rw_q),
        .resp_beat_i (m_resp_valid && m_resp_ready && !resp_sel),
        .can_read_o  (can_read0)
    );

    mem_arb_out_tracker #(
        .BEATS   (BEATS),
        .MAX_OUT (MAX_OUT)
    ) u_trk1 (
        .host_clk    (host_clk),
        .reset       (reset),
        .rd_issue_i  (cmd_hs && gnt_q && !cmd_rw_q),
        .resp_beat_i (m_resp_valid && m_resp_ready && resp_sel),
        .can_read_o  (can_read1)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected downstream commands and write beats are queued
// as stimulus is driven and popped when the DUT hands them downstream.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TAG_W   = 4;
    localparam int DATA_W  = 128;
    localparam int BEATS   = 4;
    localparam int MAX_OUT = 8;

    logic              host_clk = 1'b0;
    logic              reset    = 1'b1;
    logic              r0_cmd_valid = 0, r0_cmd_rw = 0, r0_data_valid = 0, r0_resp_ready = 0;
    logic              r1_cmd_valid = 0, r1_cmd_rw = 0, r1_data_valid = 0, r1_resp_ready = 0;
    logic [25:0]       r0_cmd_addr = '0, r1_cmd_addr = '0;
    logic [TAG_W-1:0]  r0_cmd_tag = '0, r1_cmd_tag = '0;
    logic [DATA_W-1:0] r0_data_bits = '0, r1_data_bits = '0;
    logic              r0_cmd_ready, r0_data_ready, r0_resp_valid;
    logic              r1_cmd_ready, r1_data_ready, r1_resp_valid;
    logic [DATA_W-1:0] r0_resp_data, r1_resp_data;
    logic [TAG_W-1:0]  r0_resp_tag, r1_resp_tag;
    logic              m_cmd_valid, m_cmd_rw, m_data_valid, m_resp_ready;
    logic              m_cmd_ready = 1'b1, m_data_ready = 1'b1, m_resp_valid = 1'b0;
    logic [25:0]       m_cmd_addr;
    logic [TAG_W:0]    m_cmd_tag;
    logic [DATA_W-1:0] m_data_bits;
    logic [DATA_W-1:0] m_resp_data = '0;
    logic [TAG_W:0]    m_resp_tag = '0;

    always #5 host_clk = ~host_clk;

    mem_port_arbiter #(
        .TAG_W(TAG_W), .DATA_W(DATA_W), .BEATS(BEATS), .MAX_OUT(MAX_OUT)
    ) dut (
        .host_clk(host_clk), .reset(reset),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_addr(r0_cmd_addr),
        .r0_cmd_tag(r0_cmd_tag), .r0_cmd_rw(r0_cmd_rw), .r0_data_valid(r0_data_valid),
        .r0_data_ready(r0_data_ready), .r0_data_bits(r0_data_bits), .r0_resp_valid(r0_resp_valid),
        .r0_resp_ready(r0_resp_ready), .r0_resp_data(r0_resp_data), .r0_resp_tag(r0_resp_tag),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_addr(r1_cmd_addr),
        .r1_cmd_tag(r1_cmd_tag), .r1_cmd_rw(r1_cmd_rw), .r1_data_valid(r1_data_valid),
        .r1_data_ready(r1_data_ready), .r1_data_bits(r1_data_bits), .r1_resp_valid(r1_resp_valid),
        .r1_resp_ready(r1_resp_ready), .r1_resp_data(r1_resp_data), .r1_resp_tag(r1_resp_tag),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_tag(m_cmd_tag), .m_cmd_rw(m_cmd_rw), .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready), .m_data_bits(m_data_bits), .m_resp_valid(m_resp_valid),
        .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data), .m_resp_tag(m_resp_tag)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    int last_data_cyc = 0;
    int cmd_rise_cyc  = 0;
    logic cmdv_prev = 1'b0;
    logic [31:0]       exp_cmd[$];
    logic [DATA_W-1:0] exp_data[$];

    function automatic logic [31:0] pack_cmd(input logic rw, input logic [4:0] tag, input logic [25:0] addr);
        return {rw, tag, addr};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge host_clk) cyc_cnt = cyc_cnt + 1;

    // Downstream monitor: every accepted command and write beat must match the scoreboard head.
    always @(negedge host_clk) begin
        if (!reset) begin
            if (m_cmd_valid && !cmdv_prev) cmd_rise_cyc = cyc_cnt;
            if (m_cmd_valid && m_cmd_ready) begin
                check("cmd_expected", 256'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0)
                    check("cmd", pack_cmd(m_cmd_rw, m_cmd_tag, m_cmd_addr), exp_cmd.pop_front());
            end
            if (m_data_valid && m_data_ready) begin
                last_data_cyc = cyc_cnt;
                check("data_expected", 256'(exp_data.size() != 0), 1);
                if (exp_data.size() != 0)
                    check("data", m_data_bits, exp_data.pop_front());
            end
        end
        cmdv_prev = m_cmd_valid;
    end

    task automatic tick();
        @(posedge host_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_cmd_hs(input int i, input string tag);
        bit hs = 1'b0;
        int b  = 0;
        while (!hs && b < 40) begin
            @(negedge host_clk);
            hs = (i == 0) ? (r0_cmd_valid && r0_cmd_ready) : (r1_cmd_valid && r1_cmd_ready);
            tick();
            b++;
        end
        if (i == 0) r0_cmd_valid = 1'b0;
        else        r1_cmd_valid = 1'b0;
        check({tag, "_cmd_hs"}, 256'(hs), 1);
    endtask

    // Streams r0 write beats base+k, optionally stalling m_data_ready after stall_at beats.
    task automatic feed_r0(input int n, input logic [DATA_W-1:0] base, input int stall_at, input int stall_len);
        int k = 0, st = 0, b = 0;
        bit hs, chs;
        r0_data_valid = 1'b1;
        r0_data_bits  = base;
        while (k < n && b < 60) begin
            if (k == stall_at && st < stall_len) begin
                m_data_ready = 1'b0;
                st++;
            end else begin
                m_data_ready = 1'b1;
            end
            @(negedge host_clk);
            if (!m_data_ready) begin
                check("stall_r0_data_ready", 256'(r0_data_ready), 0);
                check("stall_wbeat", 256'(dut.wbeat_q), 256'(stall_at));
            end
            hs  = r0_data_valid && r0_data_ready;
            chs = r0_cmd_valid && r0_cmd_ready;
            tick();
            if (chs) r0_cmd_valid = 1'b0;
            if (hs) begin
                k++;
                r0_data_bits = base + DATA_W'(k);
            end
            b++;
        end
        r0_data_valid = 1'b0;
        m_data_ready  = 1'b1;
        check("feed_beats_done", 256'(k), 256'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] base;

        // Reset state
        do_reset();
        check("rst_m_cmd_valid", 256'(m_cmd_valid), 0);
        check("rst_m_cmd_fields", {m_cmd_rw, m_cmd_tag, m_cmd_addr}, 0);
        check("rst_m_data_valid", 256'(m_data_valid), 0);
        check("rst_cmd_ready", {r0_cmd_ready, r1_cmd_ready}, 0);
        check("rst_data_ready", {r0_data_ready, r1_data_ready}, 0);
        check("rst_state", 256'(dut.state_q), 256'(IDLE));

        // Both requesters read continuously: grants alternate r0, r1, r0
        r0_cmd_valid = 1; r0_cmd_addr = 26'h0A0; r0_cmd_tag = 4'h1; r0_cmd_rw = 0;
        r1_cmd_valid = 1; r1_cmd_addr = 26'h0B0; r1_cmd_tag = 4'h2; r1_cmd_rw = 0;
        exp_cmd.push_back(pack_cmd(1'b0, 5'h01, 26'h0A0));
        exp_cmd.push_back(pack_cmd(1'b0, 5'h12, 26'h0B0));
        exp_cmd.push_back(pack_cmd(1'b0, 5'h01, 26'h0A0));
        repeat (6) tick();
        r0_cmd_valid = 0; r1_cmd_valid = 0;
        tick(); tick();
        check("rr_cmds_left", 256'(exp_cmd.size()), 0);

        // r0 write holds the port; pending r1 read follows 2 cycles after the last beat
        do_reset();
        base = 128'hA000_0000_0000_0000_0000_0000_0000_0000;
        r0_cmd_valid = 1; r0_cmd_addr = 26'h100; r0_cmd_tag = 4'h5; r0_cmd_rw = 1;
        r1_cmd_valid = 1; r1_cmd_addr = 26'h200; r1_cmd_tag = 4'h6; r1_cmd_rw = 0;
        exp_cmd.push_back(pack_cmd(1'b1, 5'h05, 26'h100));
        exp_cmd.push_back(pack_cmd(1'b0, 5'h16, 26'h200));
        for (int k = 0; k < BEATS; k++) exp_data.push_back(base + DATA_W'(k));
        feed_r0(BEATS, base, -1, 0);
        wait_cmd_hs(1, "wr_then_rd");
        check("rd_after_wr_gap", 256'(cmd_rise_cyc - last_data_cyc), 2);
        check("wr_cmds_left", 256'(exp_cmd.size()), 0);
        check("wr_data_left", 256'(exp_data.size()), 0);

        // Downstream data stall for 3 cycles mid-write
        do_reset();
        base = 128'hB000_0000_0000_0000_0000_0000_0000_0010;
        r0_cmd_valid = 1; r0_cmd_addr = 26'h140; r0_cmd_tag = 4'h7; r0_cmd_rw = 1;
        exp_cmd.push_back(pack_cmd(1'b1, 5'h07, 26'h140));
        for (int k = 0; k < BEATS; k++) exp_data.push_back(base + DATA_W'(k));
        feed_r0(BEATS, base, 2, 3);
        tick();
        check("stall_data_left", 256'(exp_data.size()), 0);
        check("stall_state_idle", 256'(dut.state_q), 256'(IDLE));

        // r1 outstanding cap: 8 reads accepted, 9th blocked until one line returns
        do_reset();
        for (int n = 0; n < MAX_OUT; n++) begin
            r1_cmd_valid = 1; r1_cmd_addr = 26'h300 + 26'(n); r1_cmd_tag = 4'(n); r1_cmd_rw = 0;
            exp_cmd.push_back(pack_cmd(1'b0, {1'b1, 4'(n)}, 26'h300 + 26'(n)));
            wait_cmd_hs(1, "cap_read");
        end
        r1_cmd_valid = 1; r1_cmd_addr = 26'h308; r1_cmd_tag = 4'h8; r1_cmd_rw = 0;
        exp_cmd.push_back(pack_cmd(1'b0, 5'h18, 26'h308));
        for (int c = 0; c < 4; c++) begin
            @(negedge host_clk);
            check("cap_r1_cmd_ready", 256'(r1_cmd_ready), 0);
            check("cap_m_cmd_valid", 256'(m_cmd_valid), 0);
            tick();
        end
        check("cap_out_cnt_full", 256'(dut.u_trk1.out_cnt_q), 8);
        r1_resp_ready = 1;
        base = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000;
        for (int b = 0; b < BEATS; b++) begin
            m_resp_valid = 1; m_resp_tag = 5'h10; m_resp_data = base + DATA_W'(b);
            @(negedge host_clk);
            check("cap_r1_resp_valid", 256'(r1_resp_valid), 1);
            check("cap_r1_resp_data", r1_resp_data, base + DATA_W'(b));
            check("cap_r1_resp_tag", 256'(r1_resp_tag), 0);
            check("cap_r0_resp_valid", 256'(r0_resp_valid), 0);
            tick();
        end
        m_resp_valid = 0; m_resp_tag = '0; m_resp_data = '0;
        check("cap_out_cnt_after_line", 256'(dut.u_trk1.out_cnt_q), 7);
        wait_cmd_hs(1, "cap_ninth");
        check("cap_cmds_left", 256'(exp_cmd.size()), 0);
        r1_resp_ready = 0;

        // Response steering by tag MSB, with r1 backpressure
        do_reset();
        r0_resp_ready = 1; r1_resp_ready = 0;
        m_resp_valid = 1; m_resp_tag = 5'h03; m_resp_data = 128'h1111;
        @(negedge host_clk);
        check("resp0_valid", {r0_resp_valid, r1_resp_valid}, 2'b10);
        check("resp0_tag", 256'(r0_resp_tag), 4'h3);
        check("resp0_data", r0_resp_data, 128'h1111);
        check("resp0_m_ready", 256'(m_resp_ready), 1);
        tick();
        m_resp_tag = 5'h13; m_resp_data = 128'h2222;
        for (int c = 0; c < 2; c++) begin
            @(negedge host_clk);
            check("resp1_valid", {r0_resp_valid, r1_resp_valid}, 2'b01);
            check("resp1_tag", 256'(r1_resp_tag), 4'h3);
            check("resp1_data", r1_resp_data, 128'h2222);
            check("resp1_m_ready_held", 256'(m_resp_ready), 0);
            tick();
        end
        r1_resp_ready = 1;
        @(negedge host_clk);
        check("resp1_m_ready_release", 256'(m_resp_ready), 1);
        tick();
        m_resp_valid = 0; m_resp_tag = '0; m_resp_data = '0;
        r0_resp_ready = 0; r1_resp_ready = 0;

        // Reset in WDATA after 2 beats drops the line; r1 read wins first afterwards
        do_reset();
        base = 128'hD000_0000_0000_0000_0000_0000_0000_0020;
        r0_cmd_valid = 1; r0_cmd_addr = 26'h180; r0_cmd_tag = 4'h9; r0_cmd_rw = 1;
        exp_cmd.push_back(pack_cmd(1'b1, 5'h09, 26'h180));
        for (int k = 0; k < 2; k++) exp_data.push_back(base + DATA_W'(k));
        feed_r0(2, base, -1, 0);
        check("mid_state_wdata", 256'(dut.state_q), 256'(WDATA));
        check("mid_wbeat", 256'(dut.wbeat_q), 2);
        r1_cmd_valid = 1; r1_cmd_addr = 26'h2C0; r1_cmd_tag = 4'hA; r1_cmd_rw = 0;
        reset = 1;
        tick();
        check("midrst_state", 256'(dut.state_q), 256'(IDLE));
        check("midrst_m_cmd", {m_cmd_valid, m_cmd_rw, m_cmd_tag, m_cmd_addr}, 0);
        check("midrst_m_data", {m_data_valid, m_data_bits}, 0);
        check("midrst_readies", {r0_cmd_ready, r1_cmd_ready, r0_data_ready, r1_data_ready, m_resp_ready}, 0);
        check("midrst_resp_valid", {r0_resp_valid, r1_resp_valid}, 0);
        reset = 0;
        exp_cmd.push_back(pack_cmd(1'b0, 5'h1A, 26'h2C0));
        wait_cmd_hs(1, "post_reset_r1");
        tick();
        check("final_cmds_left", 256'(exp_cmd.size()), 0);
        check("final_data_left", 256'(exp_data.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single test-chip memory port in front of the Zynq HP0 AXI bridge. It sits between the bridge's MemIO-style cmd/data/resp interface and two MemIO masters: requester 0 (the Rocket core memory port) and requester 1 (a host-side loader/DMA). It serialises commands round-robin and holds the data channel on a write's owner until the full line is sent. It also steers responses back by tag and caps per-requester outstanding reads.

## Interface
Parameters:
- TAG_W, 4, upstream tag width; downstream tag is TAG_W+1 with requester ID in the MSB
- DATA_W, 128, MemIO data beat width
- BEATS, 4, data beats per line (one 8×64-bit AXI burst)
- MAX_OUT, 8, max outstanding reads per requester (power of two)

Ports (`r{i}` = r0 and r1, identical sets):
- host_clk  in  1  clock
- reset  in  1  synchronous, active-high
- r{i}_cmd_valid / r{i}_cmd_ready  in / out  1  command handshake
- r{i}_cmd_addr  in  26  line address
- r{i}_cmd_tag  in  TAG_W  request tag
- r{i}_cmd_rw  in  1  1 = write
- r{i}_data_valid / r{i}_data_ready  in / out  1  write-data handshake
- r{i}_data_bits  in  DATA_W  write data
- r{i}_resp_valid / r{i}_resp_ready  out / in  1  response handshake
- r{i}_resp_data  out  DATA_W  read data
- r{i}_resp_tag  out  TAG_W  response tag
- m_cmd_valid / m_cmd_ready  out / in  1  downstream command handshake
- m_cmd_addr, m_cmd_tag, m_cmd_rw  out  26, TAG_W+1, 1  downstream command fields
- m_data_valid / m_data_ready  out / in  1  downstream write-data handshake
- m_data_bits  out  DATA_W  downstream write data
- m_resp_valid / m_resp_ready  in / out  1  downstream response handshake
- m_resp_data  in  DATA_W  downstream read data
- m_resp_tag  in  TAG_W+1  downstream response tag

## Operation
- FSM states:
  - IDLE: pick a winner among eligible requesters and register `gnt`.
  - CMD: present the winner's command downstream.
  - WDATA: forward the remaining write beats.
- Eligibility: `cmd_valid`, and for reads also `out_cnt[i] < MAX_OUT`. Writes do not count toward the outstanding limit.
- Round-robin: pointer `prio` favours r0 after reset. On each downstream cmd handshake, `prio` moves to the other requester. If only one requester is eligible, it wins.
- CMD state:
  - `m_cmd_*` come from `gnt`; `m_cmd_tag = {gnt, r_gnt_cmd_tag}`.
  - `r_gnt_cmd_ready = m_cmd_ready`; the other requester's cmd_ready is 0.
- Data channel in CMD and WDATA:
  - `m_data_valid/bits` muxed from `gnt`; `r_gnt_data_ready = m_data_ready`.
  - The data mux is active during CMD because the bridge needs data_valid alongside a write command.
  - Beat counter `wbeat` (log2 BEATS bits) counts data handshakes.
- Transitions on the cmd handshake:
  - Read: go to IDLE.
  - Write: go to WDATA. If BEATS beats were already sent, go to IDLE instead.
- WDATA: return to IDLE on the BEATS-th data handshake; `wbeat` clears to 0.
- Responses:
  - Routed combinationally by `m_resp_tag[TAG_W]`.
  - `r{sel}_resp_valid = m_resp_valid`; resp_data passes through; `resp_tag = m_resp_tag[TAG_W-1:0]`.
  - `m_resp_ready = r{sel}_resp_ready`; the non-selected resp_valid is 0.
- Outstanding tracking, per requester:
  - `rbeat[i]` counts response beats mod BEATS.
  - `out_cnt[i]` increments on a read cmd handshake and decrements on the BEATS-th response beat.
  - A simultaneous increment and decrement leaves it unchanged.
  - Width is log2(MAX_OUT)+1.

## Timing
- Reset (synchronous) puts all outputs at 0: every valid/ready low, `m_cmd_*` fields 0.
- Reset clears state to IDLE, and clears `prio`, `gnt`, `wbeat`, `rbeat[]` and `out_cnt[]`.
- Reset mid-write drops the partial line; the requester must reissue it.
- Command latency: a cmd_valid seen in IDLE drives m_cmd_valid in the next cycle. Back-to-back commands are spaced at least 2 cycles apart (IDLE → CMD).
- The winner's command is held stable in CMD until accepted. A requester that deasserts cmd_valid in CMD is a protocol violation; the block keeps driving the registered `gnt` fields regardless.
- No new command is granted while in WDATA. Responses flow in every state.
- Response path has zero latency (combinational).
- A read cmd is allowed even if its response beats start the same cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - FSM state enum.
  - Default values for TAG_W, DATA_W, BEATS and MAX_OUT.
  - Requester-ID bit position helper.
- Natural sub-module: `mem_arb_out_tracker`, instantiated once per requester. It holds `rbeat` and `out_cnt` and outputs `can_read = out_cnt < MAX_OUT`.

## Test plan
- Both requesters issue continuous reads from the same cycle, m_cmd_ready = 1 → accepted tags alternate r0, r1, r0; m_cmd_tag MSB toggles 0, 1, 0.
- r0 write (addr 0x100, 4 beats; data_valid asserted with cmd) while r1 read is pending → r1 cmd is not forwarded until the 4th r0 data handshake; the r1 command appears 2 cycles later.
- m_data_ready held low for 3 cycles mid-write → `wbeat` stalls, r0_data_ready is low, no beat is lost or duplicated, and 4 beats reach downstream in order.
- r1 issues 8 reads with no responses → r1_cmd_ready stays 0 on the 9th read. Return 4 beats with tag 5'h10 → out_cnt[1] = 7 and the 9th read is accepted.
- Response beats carrying tag 5'h03 and then 5'h13 → r0_resp_tag = 4'h3, then r1_resp_tag = 4'h3. r1_resp_ready = 0 holds m_resp_ready at 0 during the r1 beats.
- Assert reset during WDATA after 2 beats → next cycle all outputs are 0 and state is IDLE; a fresh r1 read is granted first after reset (`prio` = 0 but r0 idle).
